// File: rtl/moduladorhw.sv
// moduladorhw: three-phase sinusoidal PWM, 120-degree spaced sine references scaled by mod, compared against one triangular carrier.
// Latency: gate outputs are registered; the output at cycle n+1 reflects the carrier at cycle n.
// No backpressure (free-running). Optional dead-time insertion is built when MODULADORHW_DEADTIME_EN is defined.
module moduladorhw #(
  parameter int CARRIER_MAX = 127,
  parameter int DEAD_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] mod,
  output logic [1:0] out1,
  output logic [1:0] out2,
  output logic [1:0] out3
);

  // Carrier extremes in the 9-bit signed carrier domain.
  localparam logic signed [8:0] C_TOP = 9'(CARRIER_MAX);
  localparam logic signed [8:0] C_BOT = 9'(-CARRIER_MAX);
  localparam logic signed [8:0] C_ONE = 9'sd1;

  // Parameter sanity: the carrier must fit 9 bits signed and dead time must be at least one clock.
  if (CARRIER_MAX < 1 || CARRIER_MAX > 255) begin : g_bad_carrier_max
    $error("CARRIER_MAX out of range for a 9-bit signed carrier");
  end
  if (DEAD_CYCLES < 1) begin : g_bad_dead_cycles
    $error("DEAD_CYCLES must be at least 1");
  end

  // 48-entry quarter-symmetric sine table, entry k = round(127*sin(2*pi*k/48)).
  function automatic logic signed [7:0] sine_lut(input logic [5:0] k);
    logic signed [7:0] s;
    s = 8'sd0;
    case (k)
      6'd0:  s = 8'sd0;
      6'd1:  s = 8'sd17;
      6'd2:  s = 8'sd33;
      6'd3:  s = 8'sd49;
      6'd4:  s = 8'sd64;
      6'd5:  s = 8'sd77;
      6'd6:  s = 8'sd90;
      6'd7:  s = 8'sd101;
      6'd8:  s = 8'sd110;
      6'd9:  s = 8'sd117;
      6'd10: s = 8'sd123;
      6'd11: s = 8'sd126;
      6'd12: s = 8'sd127;
      6'd13: s = 8'sd126;
      6'd14: s = 8'sd123;
      6'd15: s = 8'sd117;
      6'd16: s = 8'sd110;
      6'd17: s = 8'sd101;
      6'd18: s = 8'sd90;
      6'd19: s = 8'sd77;
      6'd20: s = 8'sd64;
      6'd21: s = 8'sd49;
      6'd22: s = 8'sd33;
      6'd23: s = 8'sd17;
      6'd24: s = 8'sd0;
      6'd25: s = -8'sd17;
      6'd26: s = -8'sd33;
      6'd27: s = -8'sd49;
      6'd28: s = -8'sd64;
      6'd29: s = -8'sd77;
      6'd30: s = -8'sd90;
      6'd31: s = -8'sd101;
      6'd32: s = -8'sd110;
      6'd33: s = -8'sd117;
      6'd34: s = -8'sd123;
      6'd35: s = -8'sd126;
      6'd36: s = -8'sd127;
      6'd37: s = -8'sd126;
      6'd38: s = -8'sd123;
      6'd39: s = -8'sd117;
      6'd40: s = -8'sd110;
      6'd41: s = -8'sd101;
      6'd42: s = -8'sd90;
      6'd43: s = -8'sd77;
      6'd44: s = -8'sd64;
      6'd45: s = -8'sd49;
      6'd46: s = -8'sd33;
      6'd47: s = -8'sd17;
      default: s = 8'sd0;
    endcase
    return s;
  endfunction

  // Amplitude scaling: full 16-bit signed product, arithmetic shift by 7.
  // |lut| <= 127 keeps the result inside -127..127, so truncation to 8 bits never wraps.
  function automatic logic signed [7:0] scale(input logic signed [7:0] m, input logic signed [7:0] s);
    logic signed [15:0] p;
    p = m * s;
    return 8'(p >>> 7);
  endfunction

  logic signed [8:0] carrier;
  logic              dir_up;
  logic [5:0]        idx;
  logic signed [7:0] mod_reg;

  logic [5:0]        ph_idx [3];
  logic signed [7:0] ref_v  [3];
  logic [2:0]        raw_hi;
  logic [1:0]        gate   [3];

  // Triangular carrier; the period rollover at the minimum advances the phase index and latches a new amplitude.
  always_ff @(posedge clk) begin
    if (rst) begin
      carrier <= C_BOT;
      dir_up  <= 1'b1;
      idx     <= 6'd0;
      mod_reg <= $signed(mod);
    end else if (dir_up) begin
      carrier <= carrier + C_ONE;
      if (carrier == C_TOP - C_ONE) begin
        dir_up <= 1'b0;
      end
    end else begin
      carrier <= carrier - C_ONE;
      if (carrier == C_BOT + C_ONE) begin
        dir_up  <= 1'b1;
        idx     <= (idx == 6'd47) ? 6'd0 : idx + 6'd1;
        mod_reg <= $signed(mod);
      end
    end
  end

  // Per-phase table index, sine reference and raw carrier comparison (B = idx+32, C = idx+16, modulo 48).
  always_comb begin
    ph_idx[0] = idx;
    ph_idx[1] = (idx >= 6'd16) ? idx - 6'd16 : idx + 6'd32;
    ph_idx[2] = (idx >= 6'd32) ? idx - 6'd32 : idx + 6'd16;
    raw_hi    = 3'b000;
    for (int i = 0; i < 3; i++) begin
      ref_v[i]  = scale(mod_reg, sine_lut(ph_idx[i]));
      raw_hi[i] = $signed({ref_v[i][7], ref_v[i]}) > carrier;
    end
  end

`ifdef MODULADORHW_DEADTIME_EN
  localparam int CW = (DEAD_CYCLES < 1) ? 1 : $clog2(DEAD_CYCLES + 1);

  logic [CW-1:0] cnt [3];
  logic [2:0]    dead;
  logic [2:0]    init;
  logic [2:0]    tgt;

  // Dead-time insertion: any change of the comparison result forces 00 for DEAD_CYCLES clocks before
  // the new state is driven; a further change while dead restarts the wait toward the latest target.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        gate[i] <= 2'b00;
        cnt[i]  <= CW'(DEAD_CYCLES);
      end
      dead <= 3'b111;
      init <= 3'b111;
      tgt  <= 3'b000;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (!dead[i]) begin
          if (raw_hi[i] != gate[i][1]) begin
            gate[i] <= 2'b00;
            dead[i] <= 1'b1;
            tgt[i]  <= raw_hi[i];
            cnt[i]  <= CW'(DEAD_CYCLES - 1);
          end else begin
            gate[i] <= {raw_hi[i], ~raw_hi[i]};
          end
        end else if (init[i]) begin
          // Post-reset hold: no state has been driven yet, so just wait out the interval.
          if (cnt[i] == '0) begin
            gate[i] <= {raw_hi[i], ~raw_hi[i]};
            dead[i] <= 1'b0;
            init[i] <= 1'b0;
          end else begin
            cnt[i] <= cnt[i] - CW'(1);
          end
        end else if (raw_hi[i] != tgt[i]) begin
          tgt[i] <= raw_hi[i];
          cnt[i] <= CW'(DEAD_CYCLES - 1);
        end else if (cnt[i] == '0) begin
          gate[i] <= {tgt[i], ~tgt[i]};
          dead[i] <= 1'b0;
        end else begin
          cnt[i] <= cnt[i] - CW'(1);
        end
      end
    end
  end
`else
  // Complementary gate pair straight from the comparison, one register stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        gate[i] <= 2'b00;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        gate[i] <= {raw_hi[i], ~raw_hi[i]};
      end
    end
  end
`endif

  assign out1 = gate[0];
  assign out2 = gate[1];
  assign out3 = gate[2];

endmodule

// File: tb/tb_moduladorhw.sv
// Bench for moduladorhw: a reference model pushes the expected gate triple for every clock into a
// scoreboard queue, a monitor pops and compares each cycle; directed periods also check duty counts.
module tb_moduladorhw;

  localparam int CMAX = 127;
  localparam int PER  = 4 * CMAX;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] mod = 8'd0;
  logic [1:0] out1, out2, out3;

  int checks = 0;
  int errors = 0;

  logic [5:0] exp_q [$];
  int         sine_tab [48];

  moduladorhw dut (
    .clk  (clk),
    .rst  (rst),
    .mod  (mod),
    .out1 (out1),
    .out2 (out2),
    .out3 (out3)
  );

  always #5 clk = ~clk;

  // Mathematical rounding of 127*sin, half away from zero; the small bias absorbs float error at .5 ties.
  function automatic int sine_val(input int k);
    real x;
    x = 127.0 * $sin(2.0 * 3.14159265358979 * k / 48.0);
    if (x >= 0.0) return $rtoi(x + 0.5 + 1.0e-6);
    return -$rtoi(-x + 0.5 + 1.0e-6);
  endfunction

  // Triangle carrier as a function of clocks since reset.
  function automatic int carrier_at(input int t);
    int p;
    p = t % PER;
    return (p <= 2 * CMAX) ? p - CMAX : 3 * CMAX - p;
  endfunction

  // floor(m * sine / 128)
  function automatic int ref_of(input int m, input int k);
    int p, q;
    p = m * sine_tab[k];
    q = p / 128;
    if (p < 0 && q * 128 != p) q = q - 1;
    return q;
  endfunction

  function automatic logic [1:0] gate_of(input int m, input int k, input int c);
    return (ref_of(m, k) > c) ? 2'b10 : 2'b01;
  endfunction

  // Reference model: on every rising edge, predict the outputs that edge produces.
  initial begin : model
    int  t;
    int  mreg;
    int  c;
    int  k;
    bit  active;
    for (int i = 0; i < 48; i++) sine_tab[i] = sine_val(i);
    active = 1'b0;
    t      = 0;
    mreg   = 0;
    forever begin
      @(posedge clk);
      if (rst) begin
        active = 1'b1;
        t      = 0;
        mreg   = int'($signed(mod));
        exp_q.push_back(6'b000000);
      end else if (active) begin
        c = carrier_at(t);
        k = (t / PER) % 48;
        exp_q.push_back({gate_of(mreg, k, c), gate_of(mreg, (k + 32) % 48, c), gate_of(mreg, (k + 16) % 48, c)});
        t = t + 1;
        if (t % PER == 0) mreg = int'($signed(mod));
      end
    end
  end

  // Monitor: compare each cycle's outputs against the oldest prediction.
  initial begin : monitor
    logic [5:0] e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if ({out1, out2, out3} !== e) begin
          errors++;
          $display("FAIL gates @%0t got %b %b %b required %b %b %b",
                   $time, out1, out2, out3, e[5:4], e[3:2], e[1:0]);
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s got %0d required %0d", name, act, req);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One-clock reset pulse with amplitude m; returns at the falling edge after the reset edge.
  task automatic do_reset(input logic [7:0] m);
    rst = 1'b1;
    mod = m;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Count high-side clocks per phase over one carrier period; optionally change mod part-way.
  task automatic count_period(input int chg_at, input logic [7:0] m2, output int h1, output int h2, output int h3);
    h1 = 0;
    h2 = 0;
    h3 = 0;
    for (int i = 0; i < PER; i++) begin
      if (i == chg_at) mod = m2;
      @(negedge clk);
      if (out1 == 2'b10) h1++;
      if (out2 == 2'b10) h2++;
      if (out3 == 2'b10) h3++;
    end
  endtask

  initial begin : stimulus
    int h1, h2, h3;
    @(negedge clk);

    // Zero amplitude: reset state, then 253 high clocks per period on every phase.
    do_reset(8'd0);
    chk("reset_gates", int'({out1, out2, out3}), 0);
    count_period(-1, 8'd0, h1, h2, h3);
    chk("m0_dutyA", h1, 253);
    chk("m0_dutyB", h2, 253);
    chk("m0_dutyC", h3, 253);

    // mod=60, idx=0: A ref 0, B ref -52, C ref 51.
    do_reset(8'd60);
    count_period(-1, 8'd60, h1, h2, h3);
    chk("p60_dutyA", h1, 253);
    chk("p60_dutyB", h2, 149);
    chk("p60_dutyC", h3, 355);
    step(PER);

    // mod=-60: B and C roles swap, A unchanged.
    do_reset(8'hC4);
    count_period(-1, 8'hC4, h1, h2, h3);
    chk("n60_dutyA", h1, 253);
    chk("n60_dutyB", h2, 355);
    chk("n60_dutyC", h3, 149);

    // Mid-period change 60 -> -60 only lands at the next carrier minimum (idx 1, A ref -8).
    do_reset(8'd60);
    count_period(PER / 2, 8'hC4, h1, h2, h3);
    chk("chg_hold_dutyA", h1, 253);
    chk("chg_hold_dutyB", h2, 149);
    chk("chg_hold_dutyC", h3, 355);
    count_period(-1, 8'hC4, h1, h2, h3);
    chk("chg_new_dutyA", h1, 237);

    // Full-scale negative amplitude for 48 periods, then index wraps back to 0.
    do_reset(8'h80);
    step(48 * PER);
    count_period(-1, 8'h80, h1, h2, h3);
    chk("wrap_dutyA", h1, 253);
    chk("wrap_dutyB", h2, 473);
    chk("wrap_dutyC", h3, 33);

    // Full-scale positive amplitude without reset.
    mod = 8'd127;
    step(10 * PER);

    // Random amplitudes at random times, with occasional mid-operation resets.
    for (int i = 0; i < 20; i++) begin
      mod = 8'($urandom_range(0, 255));
      step($urandom_range(1, 600));
      if ($urandom_range(0, 4) == 0) do_reset(8'($urandom_range(0, 255)));
    end

    step(3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
